// File: rtl/wb_arbiter.sv
// Write-back arbiter: shares one register-file write port among MUL, ALU and LSU.
// MUL always wins. ALU/LSU contention is resolved by a 1-bit round-robin pointer.
module wb_arbiter #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mul_valid,
    // Packed MUL record: bits [XLEN+4:XLEN] are rd, bits [XLEN-1:0] are the result.
    input  logic [XLEN+4:0]    mul_wb_inf,
    input  logic               alu_valid,
    input  logic [4:0]         alu_rd,
    input  logic [XLEN-1:0]    alu_result,
    output logic               alu_ready,
    input  logic               lsu_valid,
    input  logic [4:0]         lsu_rd,
    input  logic [XLEN-1:0]    lsu_result,
    output logic               lsu_ready,
    output logic               rf_we,
    output logic [4:0]         rf_waddr,
    output logic [XLEN-1:0]    rf_wdata,
    output logic [CNT_W-1:0]   stall_cnt
);

    logic             rr_q, rr_d;
    logic             rf_we_q, we_d;
    logic [4:0]       rf_waddr_q, waddr_d;
    logic [XLEN-1:0]  rf_wdata_q, wdata_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             alu_gnt, lsu_gnt, stall;

    // Grants are gated by reset so nothing handshakes while the block is held.
    always_comb begin
        alu_gnt = 1'b0;
        lsu_gnt = 1'b0;
        if (!rst && !mul_valid) begin
            if (alu_valid && lsu_valid) begin
                alu_gnt = ~rr_q;
                lsu_gnt = rr_q;
            end else begin
                alu_gnt = alu_valid;
                lsu_gnt = lsu_valid;
            end
        end
    end

    assign alu_ready = alu_gnt;
    assign lsu_ready = lsu_gnt;
    assign stall     = (alu_valid & ~alu_gnt) | (lsu_valid & ~lsu_gnt);

    always_comb begin
        we_d    = 1'b0;
        waddr_d = rf_waddr_q;
        wdata_d = rf_wdata_q;
        if (mul_valid) begin
            we_d    = (mul_wb_inf[XLEN+4:XLEN] != 5'd0);
            waddr_d = mul_wb_inf[XLEN+4:XLEN];
            wdata_d = mul_wb_inf[XLEN-1:0];
        end else if (alu_gnt) begin
            we_d    = (alu_rd != 5'd0);
            waddr_d = alu_rd;
            wdata_d = alu_result;
        end else if (lsu_gnt) begin
            we_d    = (lsu_rd != 5'd0);
            waddr_d = lsu_rd;
            wdata_d = lsu_result;
        end
        // Dropped x0 writes leave the visible address/data untouched.
        if (!we_d) begin
            waddr_d = rf_waddr_q;
            wdata_d = rf_wdata_q;
        end
    end

    always_comb begin
        rr_d = rr_q;
        if (alu_valid && lsu_valid && (alu_gnt || lsu_gnt)) begin
            rr_d = ~rr_q;
        end
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_q        <= 1'b0;
            rf_we_q     <= 1'b0;
            rf_waddr_q  <= 5'd0;
            rf_wdata_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            rr_q        <= rr_d;
            rf_we_q     <= we_d;
            rf_waddr_q  <= waddr_d;
            rf_wdata_q  <= wdata_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign rf_we     = rf_we_q;
    assign rf_waddr  = rf_waddr_q;
    assign rf_wdata  = rf_wdata_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: a reference model predicts grants, writes and
// stall count; predicted writes are queued at drive time and popped one cycle later.
module tb_wb_arbiter;

    localparam int XLEN  = 32;
    localparam int CNT_W = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              mul_valid;
    logic [XLEN+4:0]   mul_wb_inf;
    logic              alu_valid;
    logic [4:0]        alu_rd;
    logic [XLEN-1:0]   alu_result;
    logic              alu_ready;
    logic              lsu_valid;
    logic [4:0]        lsu_rd;
    logic [XLEN-1:0]   lsu_result;
    logic              lsu_ready;
    logic              rf_we;
    logic [4:0]        rf_waddr;
    logic [XLEN-1:0]   rf_wdata;
    logic [CNT_W-1:0]  stall_cnt;

    int checkCount = 0;
    int failCount  = 0;

    logic              rrModel;
    logic [CNT_W-1:0]  cntModel;
    logic [4:0]        lastAddr;
    logic [XLEN-1:0]   lastData;
    logic [XLEN+5:0]   writeQueue[$];

    wb_arbiter #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .mul_valid  (mul_valid),
        .mul_wb_inf (mul_wb_inf),
        .alu_valid  (alu_valid),
        .alu_rd     (alu_rd),
        .alu_result (alu_result),
        .alu_ready  (alu_ready),
        .lsu_valid  (lsu_valid),
        .lsu_rd     (lsu_rd),
        .lsu_result (lsu_result),
        .lsu_ready  (lsu_ready),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .stall_cnt  (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic resetModel();
        rrModel  = 1'b0;
        cntModel = '0;
        lastAddr = 5'd0;
        lastData = '0;
        writeQueue.delete();
    endtask

    // Called just after a rising edge; holds reset over one edge with sources requesting.
    task automatic doReset();
        mul_valid = 1'b0;
        alu_valid = 1'b1;
        lsu_valid = 1'b1;
        rst = 1'b1;
        resetModel();
        #2;
        checkOutput("rst_rf_we", rf_we, 0);
        checkOutput("rst_rf_waddr", rf_waddr, 0);
        checkOutput("rst_rf_wdata", rf_wdata, 0);
        checkOutput("rst_stall_cnt", stall_cnt, 0);
        checkOutput("rst_alu_ready", alu_ready, 0);
        checkOutput("rst_lsu_ready", lsu_ready, 0);
        @(posedge clk);
        #1;
        checkOutput("rst_hold_rf_we", rf_we, 0);
        alu_valid = 1'b0;
        lsu_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // One cycle: drive MUL plus the currently pending ALU/LSU requests, predict and check.
    task automatic applyStimulus(input logic mv, input logic [4:0] mrd, input logic [XLEN-1:0] mres);
        logic expA, expL, expWe, stallNow;
        logic [4:0] expAddr;
        logic [XLEN-1:0] expData;
        logic [XLEN+5:0] popped;
        mul_valid  = mv;
        mul_wb_inf = {mrd, mres};
        expA = 1'b0;
        expL = 1'b0;
        if (!mv) begin
            if (alu_valid && lsu_valid) begin
                expA = ~rrModel;
                expL = rrModel;
            end else begin
                expA = alu_valid;
                expL = lsu_valid;
            end
        end
        expWe = 1'b0;
        expAddr = lastAddr;
        expData = lastData;
        if (mv) begin
            expWe = (mrd != 0); expAddr = mrd; expData = mres;
        end else if (expA) begin
            expWe = (alu_rd != 0); expAddr = alu_rd; expData = alu_result;
        end else if (expL) begin
            expWe = (lsu_rd != 0); expAddr = lsu_rd; expData = lsu_result;
        end
        if (!expWe) begin
            expAddr = lastAddr;
            expData = lastData;
        end
        lastAddr = expAddr;
        lastData = expData;
        writeQueue.push_back({expWe, expAddr, expData});
        stallNow = (alu_valid && !expA) || (lsu_valid && !expL);
        if (stallNow && cntModel != {CNT_W{1'b1}}) cntModel = cntModel + 1'b1;
        if (alu_valid && lsu_valid && (expA || expL)) rrModel = ~rrModel;

        @(negedge clk);
        checkOutput("alu_ready", alu_ready, expA);
        checkOutput("lsu_ready", lsu_ready, expL);
        @(posedge clk);
        #1;
        if (writeQueue.size() == 0) begin
            checkOutput("scoreboard_empty", 1, 0);
        end else begin
            popped = writeQueue.pop_front();
            checkOutput("rf_we", rf_we, popped[XLEN+5]);
            checkOutput("rf_waddr", rf_waddr, popped[XLEN+4:XLEN]);
            checkOutput("rf_wdata", rf_wdata, popped[XLEN-1:0]);
        end
        checkOutput("stall_cnt", stall_cnt, cntModel);
        checkOutput("rr_ptr", dut.rr_q, rrModel);
        if (expA) alu_valid = 1'b0;
        if (expL) lsu_valid = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        mul_valid  = 1'b0;
        mul_wb_inf = '0;
        alu_valid  = 1'b0;
        alu_rd     = 5'd0;
        alu_result = '0;
        lsu_valid  = 1'b0;
        lsu_rd     = 5'd0;
        lsu_result = '0;
        resetModel();
        #1;
        doReset();

        // Single ALU request
        alu_valid = 1'b1; alu_rd = 5'd5; alu_result = 32'hDEADBEEF;
        applyStimulus(1'b0, 5'd0, '0);
        applyStimulus(1'b0, 5'd0, '0);

        // MUL beats both, then ALU and LSU share the port
        doReset();
        alu_valid = 1'b1; alu_rd = 5'd4; alu_result = 32'h0000_00A4;
        lsu_valid = 1'b1; lsu_rd = 5'd6; lsu_result = 32'h0000_0066;
        applyStimulus(1'b1, 5'd3, 32'h12);
        applyStimulus(1'b0, 5'd0, '0);
        applyStimulus(1'b0, 5'd0, '0);
        applyStimulus(1'b0, 5'd0, '0);

        // Continuous ALU/LSU contention alternates grants
        doReset();
        for (int i = 0; i < 6; i++) begin
            if (!alu_valid) begin
                alu_valid = 1'b1; alu_rd = 5'($urandom_range(1, 31)); alu_result = $urandom;
            end
            if (!lsu_valid) begin
                lsu_valid = 1'b1; lsu_rd = 5'($urandom_range(1, 31)); lsu_result = $urandom;
            end
            applyStimulus(1'b0, 5'd0, '0);
        end
        alu_valid = 1'b0;
        lsu_valid = 1'b0;

        // LSU write to x0 is accepted but dropped
        lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_result = 32'hCAFEF00D;
        applyStimulus(1'b0, 5'd0, '0);
        applyStimulus(1'b0, 5'd0, '0);

        // Stall counter saturation under 20 back-to-back MUL results
        doReset();
        alu_valid = 1'b1; alu_rd = 5'd7; alu_result = 32'h7777_0007;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, 5'(i + 1), $urandom);
        end
        checkOutput("stall_saturated", stall_cnt, 15);
        applyStimulus(1'b0, 5'd0, '0);
        checkOutput("stall_stays", stall_cnt, 15);

        // Asynchronous reset discards the pending write
        doReset();
        alu_valid = 1'b1; alu_rd = 5'd9; alu_result = 32'h0909_0909;
        applyStimulus(1'b1, 5'd2, 32'h22);
        applyStimulus(1'b0, 5'd0, '0);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_rf_we", rf_we, 0);
        checkOutput("async_stall_cnt", stall_cnt, 0);
        checkOutput("async_rf_waddr", rf_waddr, 0);
        resetModel();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("post_rst_rf_we", rf_we, 0);
        alu_valid = 1'b1; alu_rd = 5'd11; alu_result = 32'hB0B0_1111;
        applyStimulus(1'b0, 5'd0, '0);
        applyStimulus(1'b0, 5'd0, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
